// File: rtl/mio_pkg.sv
// Shared types and constants for the memory/IO handshake stage.
package mio_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RAM_ACC  = 3'd1;
    localparam logic [2:0] ST_RAM_WAIT = 3'd2;
    localparam logic [2:0] ST_PERI_ACC = 3'd3;
    localparam logic [2:0] ST_RESP     = 3'd4;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        RAM_ACC  = ST_RAM_ACC,
        RAM_WAIT = ST_RAM_WAIT,
        PERI_ACC = ST_PERI_ACC,
        RESP     = ST_RESP
    } mio_state_e;

    localparam logic [3:0]  PERI_NIB_E = 4'hE;
    localparam logic [3:0]  PERI_NIB_F = 4'hF;
    localparam logic [31:0] ERR_DATA   = 32'hDEADBEEF;

    // Access captured when leaving IDLE; held stable until RESP.
    typedef struct packed {
        logic        we;
        logic        is_peri;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mio_req_t;

    function automatic logic is_peri_region(input logic [3:0] nib);
        return (nib == PERI_NIB_E) || (nib == PERI_NIB_F);
    endfunction

endpackage

// File: rtl/mio_bus_ctrl_if.sv
// CPU request, block-RAM and peripheral bus signals of the handshake stage.
// slave: the controller itself; master: the CPU/memory/peripheral side.
interface mio_bus_if #(
    parameter int unsigned RAM_AW = 10
) ();
    logic              MemRead;
    logic              MemWrite;
    logic              CPU_MIO;
    logic [31:0]       addr_bus;
    logic [31:0]       Data_out;
    logic [31:0]       Data_in;
    logic              MIO_ready;
    logic [RAM_AW-1:0] ram_addr;
    logic              ram_we;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;
    logic              peri_stb;
    logic              peri_we;
    logic [31:0]       peri_addr;
    logic [31:0]       peri_wdata;
    logic [31:0]       peri_rdata;
    logic              peri_ack;
    logic              bus_err;

    modport slave (
        input  MemRead, MemWrite, CPU_MIO, addr_bus, Data_out, ram_dout,
               peri_rdata, peri_ack,
        output Data_in, MIO_ready, ram_addr, ram_we, ram_din, peri_stb,
               peri_we, peri_addr, peri_wdata, bus_err
    );

    modport master (
        output MemRead, MemWrite, CPU_MIO, addr_bus, Data_out, ram_dout,
               peri_rdata, peri_ack,
        input  Data_in, MIO_ready, ram_addr, ram_we, ram_din, peri_stb,
               peri_we, peri_addr, peri_wdata, bus_err
    );
endinterface

// File: rtl/mio_bus_ctrl_addr_dec.sv
// Combinational target decode: peripheral region and RAM word address.
module mio_addr_dec
    import mio_pkg::*;
#(
    parameter int unsigned RAM_AW = 10
) (
    input  logic [31:0]       addr_i,
    output logic              is_peri_c,
    output logic [RAM_AW-1:0] ram_waddr_c
);

    logic unused_addr;

    // Top nibble E/F is the peripheral window; RAM is word addressed.
    assign is_peri_c   = is_peri_region(addr_i[31:28]);
    assign ram_waddr_c = addr_i[RAM_AW+1:2];
    assign unused_addr = ^{addr_i[31:RAM_AW+2], addr_i[1:0]};

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO handshake stage between the multi-cycle CPU controller and the
// block RAM / peripheral bus. Optional macro MIO_TIMEOUT_EN adds a
// peripheral ack timeout with a sticky bus_err flag.
module mio_bus_ctrl
    import mio_pkg::*;
#(
    parameter int unsigned RAM_LAT = 2,
    parameter int unsigned RAM_AW  = 10,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic     clk,
    input  logic     reset,
    mio_bus_if.slave bus
);

    localparam int unsigned RAM_CW = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

    if (RAM_LAT < 1 || TIMEOUT < 1) begin : g_bad_param
        $error("mio_bus_ctrl: RAM_LAT and TIMEOUT must be >= 1");
    end

    mio_state_e        state_q, state_d;
    mio_req_t          req_q, req_d;
    logic [RAM_CW-1:0] ram_cnt_q, ram_cnt_d;
    logic [31:0]       data_in_q, data_in_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic              mio_ready_q, ram_we_q, peri_stb_q, peri_we_q;
    logic              is_peri_c;
    logic [RAM_AW-1:0] ram_waddr_c;

`ifdef MIO_TIMEOUT_EN
    localparam int unsigned TO_CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TO_CW-1:0] to_cnt_q, to_cnt_d;
    logic             bus_err_q, bus_err_d;
`endif

    mio_addr_dec #(.RAM_AW(RAM_AW)) u_dec (
        .addr_i      (bus.addr_bus),
        .is_peri_c   (is_peri_c),
        .ram_waddr_c (ram_waddr_c)
    );

    // Next-state, request latch, wait counters and read-data capture.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        ram_cnt_d  = ram_cnt_q;
        data_in_d  = data_in_q;
        ram_addr_d = ram_addr_q;
`ifdef MIO_TIMEOUT_EN
        to_cnt_d   = to_cnt_q;
        bus_err_d  = bus_err_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.CPU_MIO && (bus.MemRead || bus.MemWrite)) begin
                    req_d.we      = bus.MemWrite;
                    req_d.is_peri = is_peri_c;
                    req_d.addr    = bus.addr_bus;
                    req_d.wdata   = bus.Data_out;
                    ram_addr_d    = ram_waddr_c;
                    state_d       = is_peri_c ? PERI_ACC : RAM_ACC;
`ifdef MIO_TIMEOUT_EN
                    to_cnt_d      = '0;
`endif
                end
            end
            RAM_ACC: begin
                if (req_q.we) begin
                    state_d = RESP;
                end else begin
                    ram_cnt_d = RAM_CW'(RAM_LAT - 1);
                    state_d   = RAM_WAIT;
                end
            end
            RAM_WAIT: begin
                if (ram_cnt_q == '0) begin
                    data_in_d = bus.ram_dout;
                    state_d   = RESP;
                end else begin
                    ram_cnt_d = ram_cnt_q - RAM_CW'(1);
                end
            end
            PERI_ACC: begin
                if (bus.peri_ack) begin
                    if (!req_q.we) data_in_d = bus.peri_rdata;
                    state_d = RESP;
                end
`ifdef MIO_TIMEOUT_EN
                else if (to_cnt_q == TO_CW'(TIMEOUT - 1)) begin
                    if (!req_q.we) data_in_d = ERR_DATA;
                    bus_err_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_CW'(1);
                end
`endif
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, latched request and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            req_q       <= '0;
            ram_cnt_q   <= '0;
            data_in_q   <= '0;
            ram_addr_q  <= '0;
            mio_ready_q <= 1'b0;
            ram_we_q    <= 1'b0;
            peri_stb_q  <= 1'b0;
            peri_we_q   <= 1'b0;
`ifdef MIO_TIMEOUT_EN
            to_cnt_q    <= '0;
            bus_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            ram_cnt_q   <= ram_cnt_d;
            data_in_q   <= data_in_d;
            ram_addr_q  <= ram_addr_d;
            mio_ready_q <= (state_d == RESP);
            ram_we_q    <= (state_d == RAM_ACC) && req_d.we;
            peri_stb_q  <= (state_d == PERI_ACC);
            peri_we_q   <= (state_d == PERI_ACC) && req_d.we;
`ifdef MIO_TIMEOUT_EN
            to_cnt_q    <= to_cnt_d;
            bus_err_q   <= bus_err_d;
`endif
        end
    end

    assign bus.Data_in    = data_in_q;
    assign bus.MIO_ready  = mio_ready_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.ram_din    = req_q.wdata;
    assign bus.peri_stb   = peri_stb_q;
    assign bus.peri_we    = peri_we_q;
    assign bus.peri_addr  = req_q.addr;
    assign bus.peri_wdata = req_q.wdata;
`ifdef MIO_TIMEOUT_EN
    assign bus.bus_err    = bus_err_q;
`else
    assign bus.bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl: vector table plus scoreboard of
// expected completion latency and read data.
module tb_mio_bus_ctrl;

    localparam int unsigned RAM_AW  = 10;
    localparam int unsigned TIMEOUT = 8;

    typedef struct {
        logic        rd;
        logic        wr;
        logic        mio;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_dly;   // -1: peripheral never acks
        int          exp_lat;   // 0: no completion expected
        logic [31:0] exp_data;
        logic [9:0]  exp_raddr;
        logic        exp_peri;
    } vec_t;

    typedef struct {
        int          lat;
        logic [31:0] data;
    } sb_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    logic exp_bus_err = 1'b0;
    sb_t  sb_q[$];
    vec_t vecs[10];

    mio_bus_if #(.RAM_AW(RAM_AW)) bus ();

    mio_bus_ctrl #(
        .RAM_LAT (2),
        .RAM_AW  (RAM_AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rd, input logic wr, input logic mio,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input int ack_dly,
                                input int exp_lat, input logic [31:0] exp_data,
                                input logic [9:0] exp_raddr, input logic exp_peri);
        vec_t v;
        v.rd = rd; v.wr = wr; v.mio = mio; v.addr = addr; v.wdata = wdata;
        v.rdata = rdata; v.ack_dly = ack_dly; v.exp_lat = exp_lat;
        v.exp_data = exp_data; v.exp_raddr = exp_raddr; v.exp_peri = exp_peri;
        return v;
    endfunction

    task automatic drop_req();
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.CPU_MIO  = 1'b0;
    endtask

    // Apply one access at a negedge, hold it until MIO_ready, check side effects.
    task automatic run_vec(input vec_t v);
        int   stb_n = 0;
        int   we_n  = 0;
        int   budget;
        int   exp_stb;
        int   exp_we;
        logic seen = 1'b0;
        sb_t  e;
        exp_stb = !v.exp_peri ? 0 : (v.ack_dly < 0 ? int'(TIMEOUT) : v.ack_dly + 1);
        exp_we  = (!v.exp_peri && v.mio && v.wr) ? 1 : 0;
        budget  = (v.exp_lat > 0) ? 40 : 10;
        bus.MemRead    = v.rd;
        bus.MemWrite   = v.wr;
        bus.CPU_MIO    = v.mio;
        bus.addr_bus   = v.addr;
        bus.Data_out   = v.wdata;
        bus.ram_dout   = v.rdata;
        bus.peri_rdata = 32'h0BAD_0BAD;
        bus.peri_ack   = 1'b0;
        if (v.exp_lat > 0) sb_q.push_back('{lat: v.exp_lat, data: v.exp_data});
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) begin
                bus.addr_bus = ~v.addr;
                bus.Data_out = ~v.wdata;
            end
            bus.peri_ack   = 1'b0;
            bus.peri_rdata = 32'h0BAD_0BAD;
            if (bus.peri_stb) begin
                stb_n++;
                chk("peri_addr", bus.peri_addr, v.addr);
                chk("peri_we", 32'(bus.peri_we), 32'(v.wr));
                if (v.wr) chk("peri_wdata", bus.peri_wdata, v.wdata);
                if (v.ack_dly >= 0 && stb_n == v.ack_dly + 1) begin
                    bus.peri_ack   = 1'b1;
                    bus.peri_rdata = v.rdata;
                end
            end
            if (bus.ram_we) begin
                we_n++;
                chk("ram_we_addr", 32'(bus.ram_addr), 32'(v.exp_raddr));
                chk("ram_din", bus.ram_din, v.wdata);
            end
            if (bus.MIO_ready) begin
                seen = 1'b1;
                if (sb_q.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    chk("ready_latency", 32'(c), 32'(e.lat));
                    chk("data_in", bus.Data_in, e.data);
                end
                if (!v.exp_peri) chk("ram_addr", 32'(bus.ram_addr), 32'(v.exp_raddr));
                drop_req();
                break;
            end
        end
        if (v.exp_lat > 0 && !seen) begin
            chk("ready_timeout", 32'd0, 32'd1);
            void'(sb_q.pop_front());
        end
        if (v.exp_lat == 0) chk("no_ready", 32'(seen), 32'd0);
        drop_req();
        bus.peri_ack = 1'b0;
        @(negedge clk);
        chk("ready_single", 32'(bus.MIO_ready), 32'd0);
        chk("stb_cycles", 32'(stb_n), 32'(exp_stb));
        chk("we_cycles", 32'(we_n), 32'(exp_we));
        chk("data_hold", bus.Data_in, v.exp_data);
        chk("bus_err", 32'(bus.bus_err), 32'(exp_bus_err));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_data_in"}, bus.Data_in, 32'd0);
        chk({tag, "_ready"}, 32'(bus.MIO_ready), 32'd0);
        chk({tag, "_ram_we"}, 32'(bus.ram_we), 32'd0);
        chk({tag, "_ram_addr"}, 32'(bus.ram_addr), 32'd0);
        chk({tag, "_ram_din"}, bus.ram_din, 32'd0);
        chk({tag, "_stb"}, 32'(bus.peri_stb), 32'd0);
        chk({tag, "_pwe"}, 32'(bus.peri_we), 32'd0);
        chk({tag, "_paddr"}, bus.peri_addr, 32'd0);
        chk({tag, "_bus_err"}, 32'(bus.bus_err), 32'd0);
    endtask

    initial begin
        //          rd wr mio addr           wdata          rdata          dly lat data           raddr   peri
        vecs[0] = mk(1, 0, 1, 32'h0000_0010, 32'h0,         32'h1234_5678, 0,  4, 32'h1234_5678, 10'd4,   0);
        vecs[1] = mk(0, 1, 1, 32'h0000_0020, 32'hCAFE_0001, 32'h0,         0,  2, 32'h1234_5678, 10'd8,   0);
        vecs[2] = mk(1, 0, 1, 32'hE000_0004, 32'h0,         32'h0000_00A5, 3,  5, 32'h0000_00A5, 10'd1,   1);
        vecs[3] = mk(1, 1, 1, 32'h0000_0030, 32'hBEEF_0002, 32'h1111_1111, 0,  2, 32'h0000_00A5, 10'd12,  0);
        vecs[4] = mk(1, 0, 0, 32'hE000_0040, 32'h0,         32'h2222_2222, 0,  0, 32'h0000_00A5, 10'd0,   0);
        vecs[5] = mk(0, 1, 1, 32'hF000_1000, 32'h0000_55AA, 32'h3333_3333, 0,  2, 32'h0000_00A5, 10'd0,   1);
        vecs[6] = mk(1, 0, 1, 32'h0000_0FFC, 32'h0,         32'h0BAD_F00D, 0,  4, 32'h0BAD_F00D, 10'h3FF, 0);
        vecs[7] = mk(1, 0, 1, 32'hE123_4568, 32'h0,         32'h0000_0077, 0,  2, 32'h0000_0077, 10'd0,   1);
        vecs[8] = mk(1, 0, 1, 32'hD000_1004, 32'h0,         32'h600D_CAFE, 0,  4, 32'h600D_CAFE, 10'd1,   0);
        vecs[9] = mk(0, 1, 1, 32'h0000_0004, 32'h0F0F_F0F0, 32'h4444_4444, 0,  2, 32'h600D_CAFE, 10'd1,   0);

        drop_req();
        bus.addr_bus   = 32'h0;
        bus.Data_out   = 32'h0;
        bus.ram_dout   = 32'h0;
        bus.peri_rdata = 32'h0;
        bus.peri_ack   = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Reset while the RAM read is waiting out its latency.
        bus.MemRead  = 1'b1;
        bus.CPU_MIO  = 1'b1;
        bus.addr_bus = 32'h0000_0044;
        bus.ram_dout = 32'h5555_AAAA;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk_reset_vals("mid_rst");
        drop_req();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_vec(mk(1, 0, 1, 32'h0000_0010, 32'h0, 32'h1357_2468, 0, 4, 32'h1357_2468, 10'd4, 0));

`ifdef MIO_TIMEOUT_EN
        exp_bus_err = 1'b1;
        run_vec(mk(1, 0, 1, 32'hE000_0008, 32'h0, 32'h0, -1, int'(TIMEOUT) + 1,
                   32'hDEAD_BEEF, 10'd2, 1));
        run_vec(mk(1, 0, 1, 32'h0000_0008, 32'h0, 32'h2468_1357, 0, 4, 32'h2468_1357, 10'd2, 0));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
